// File: rtl/tpic_pkg.sv
// Shared types and constants for the TPIC daisy-chain driver.
package tpic_pkg;

  typedef enum logic [2:0] {
    S_CLR   = 3'd0,
    S_IDLE  = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  localparam int unsigned MODE_CONT   = 0;
  localparam int unsigned MODE_STROBE = 1;
  localparam int unsigned MODE_CHANGE = 2;

  // Cycles busy is high for one frame: WIDTH low/high SCLK phases plus the RCK phase.
  function automatic int unsigned frame_cycles(input int unsigned width,
                                               input int unsigned clk_div);
    return 2 * width * clk_div + clk_div;
  endfunction

endpackage

// File: rtl/tpic_phase_timer.sv
// CLK_DIV phase timer: tick marks the last cycle of a phase; load restarts the phase.
module tpic_phase_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Down-count to zero and hold there; a load starts a fresh CLK_DIV-cycle phase.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/tpic_chain_driver.sv
// Serial driver for a chain of N_DEV TPIC-style 8-bit power shift registers.
module tpic_chain_driver
  import tpic_pkg::*;
#(
  parameter int unsigned N_DEV     = 2,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned MODE      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*N_DEV-1:0] data,
  input  logic               start,
  input  logic               oe,
  output logic               busy,
  output logic               done,
  output logic               sclk,
  output logic               sout,
  output logic               rck,
  output logic               clr_n,
  output logic               g_n
);

  localparam int unsigned WIDTH = 8 * N_DEV;
  localparam int unsigned BW    = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] last_sent;
  logic [BW-1:0]    bit_cnt;
  logic             pending;
  logic             done_q;
  logic             g_n_q;
  logic             tick;
  logic             in_frame;
  logic             start_req;
  logic             trigger;

  assign in_frame  = (state == S_LO) || (state == S_HI) || (state == S_LATCH);
  assign start_req = start && (MODE != MODE_CONT);
  assign trigger   = (MODE == MODE_CONT) || start_req || pending ||
                     ((MODE == MODE_CHANGE) && (data != last_sent));

  // Outside a frame the timer is held loaded so each phase starts with a full count.
  tpic_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (!in_frame || tick),
    .tick (tick)
  );

  // Frame sequencer: launch, SCLK low/high phases per bit, RCK latch, done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CLR;
      shreg     <= '0;
      last_sent <= '0;
      bit_cnt   <= '0;
      pending   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_frame && start_req) begin
        pending <= 1'b1;
      end
      case (state)
        S_CLR: begin
          state <= S_IDLE;
        end
        S_IDLE: begin
          if (trigger) begin
            shreg     <= data;
            last_sent <= data;
            bit_cnt   <= '0;
            pending   <= 1'b0;
            state     <= S_LO;
          end
        end
        S_LO: begin
          if (tick) begin
            state <= S_HI;
          end
        end
        S_HI: begin
          if (tick) begin
            if (MSB_FIRST != 0) begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
              shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            if (bit_cnt == LAST_BIT) begin
              state <= S_LATCH;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              state   <= S_LO;
            end
          end
        end
        S_LATCH: begin
          if (tick) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= S_CLR;
        end
      endcase
    end
  end

  // Output enable is a plain registered inversion of oe, forced off in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      g_n_q <= 1'b1;
    end else begin
      g_n_q <= ~oe;
    end
  end

  assign busy  = in_frame;
  assign done  = done_q;
  assign sclk  = (state == S_HI);
  assign rck   = (state == S_LATCH);
  assign clr_n = (state != S_CLR);
  assign sout  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign g_n   = g_n_q;

endmodule

// File: tb/tb_tpic_chain_driver.sv
// Directed bench for tpic_chain_driver across four parameter sets.
module tb_tpic_chain_driver;
  import tpic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] rst;
  logic [3:0] st;
  logic [3:0] mclr;
  logic       oea;
  logic [7:0]  da, dc, dd;
  logic [15:0] db;

  logic a_busy, a_done, a_sclk, a_sout, a_rck, a_clr_n, a_g_n;
  logic b_busy, b_done, b_sclk, b_sout, b_rck, b_clr_n, b_g_n;
  logic c_busy, c_done, c_sclk, c_sout, c_rck, c_clr_n, c_g_n;
  logic d_busy, d_done, d_sclk, d_sout, d_rck, d_clr_n, d_g_n;

  tpic_chain_driver #(.N_DEV(1), .CLK_DIV(2), .MSB_FIRST(1), .MODE(1)) u_a (
    .clk(clk), .reset(rst[0]), .data(da), .start(st[0]), .oe(oea),
    .busy(a_busy), .done(a_done), .sclk(a_sclk), .sout(a_sout),
    .rck(a_rck), .clr_n(a_clr_n), .g_n(a_g_n));

  tpic_chain_driver #(.N_DEV(2), .CLK_DIV(1), .MSB_FIRST(0), .MODE(1)) u_b (
    .clk(clk), .reset(rst[1]), .data(db), .start(st[1]), .oe(1'b0),
    .busy(b_busy), .done(b_done), .sclk(b_sclk), .sout(b_sout),
    .rck(b_rck), .clr_n(b_clr_n), .g_n(b_g_n));

  tpic_chain_driver #(.N_DEV(1), .CLK_DIV(2), .MSB_FIRST(1), .MODE(2)) u_c (
    .clk(clk), .reset(rst[2]), .data(dc), .start(st[2]), .oe(1'b0),
    .busy(c_busy), .done(c_done), .sclk(c_sclk), .sout(c_sout),
    .rck(c_rck), .clr_n(c_clr_n), .g_n(c_g_n));

  tpic_chain_driver #(.N_DEV(1), .CLK_DIV(1), .MSB_FIRST(1), .MODE(0)) u_d (
    .clk(clk), .reset(rst[3]), .data(dd), .start(st[3]), .oe(1'b0),
    .busy(d_busy), .done(d_done), .sclk(d_sclk), .sout(d_sout),
    .rck(d_rck), .clr_n(d_clr_n), .g_n(d_g_n));

  // Per-instance activity monitor, sampled on the falling edge.
  typedef struct {
    int          rises;
    int          rck_cyc;
    int          busy_cyc;
    int          dones;
    int          overlap;
    logic [15:0] bits;
    logic        sclk_q;
  } mon_t;

  mon_t mon [4];

  function automatic mon_t mon_step(input mon_t m, input logic clr, input logic sclk,
                                    input logic sout, input logic rck, input logic busy,
                                    input logic done);
    mon_t n = m;
    if (clr) begin
      n.rises = 0; n.rck_cyc = 0; n.busy_cyc = 0; n.dones = 0; n.overlap = 0;
      n.bits = '0;
    end else begin
      if (sclk && !m.sclk_q) begin
        n.rises += 1;
        n.bits = {m.bits[14:0], sout};
      end
      if (rck)         n.rck_cyc += 1;
      if (busy)        n.busy_cyc += 1;
      if (done)        n.dones += 1;
      if (rck && sclk) n.overlap += 1;
    end
    n.sclk_q = sclk;
    return n;
  endfunction

  always @(negedge clk) begin
    mon[0] <= mon_step(mon[0], mclr[0], a_sclk, a_sout, a_rck, a_busy, a_done);
    mon[1] <= mon_step(mon[1], mclr[1], b_sclk, b_sout, b_rck, b_busy, b_done);
    mon[2] <= mon_step(mon[2], mclr[2], c_sclk, c_sout, c_rck, c_busy, c_done);
    mon[3] <= mon_step(mon[3], mclr[3], d_sclk, d_sout, d_rck, d_busy, d_done);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon(input int k);
    mclr[k] = 1'b1;
    cyc(1);
    mclr[k] = 1'b0;
  endtask

  task automatic pulse(input int k);
    st[k] = 1'b1;
    cyc(1);
    st[k] = 1'b0;
  endtask

  task automatic wait_dones(input int k, input int n, input int budget, input string name);
    int i = 0;
    while (mon[k].dones < n && i < budget) begin
      cyc(1);
      i++;
    end
    if (mon[k].dones < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: dones %0d expected %0d", name, mon[k].dones, n);
    end
  endtask

  typedef struct {
    int          sel;
    logic [15:0] data;
    logic [15:0] exp_bits;
    int          exp_rises;
    int          exp_busy;
    int          exp_rck;
  } vec_t;

  vec_t vt [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int k;

    vt[0] = '{0, 16'h00A5, 16'h00A5,  8, 34, 2};
    vt[1] = '{0, 16'h003C, 16'h003C,  8, 34, 2};
    vt[2] = '{0, 16'h00FF, 16'h00FF,  8, 34, 2};
    vt[3] = '{0, 16'h0001, 16'h0001,  8, 34, 2};
    vt[4] = '{1, 16'h8001, 16'h8001, 16, 33, 1};
    vt[5] = '{1, 16'h0003, 16'hC000, 16, 33, 1};
    vt[6] = '{1, 16'h1234, 16'h2C48, 16, 33, 1};
    vt[7] = '{1, 16'h00F0, 16'h0F00, 16, 33, 1};

    rst = 4'hF; st = '0; mclr = '0; oea = 1'b0;
    da = '0; db = '0; dc = '0; dd = 8'h81;

    // Reset state and clr_n pulse width.
    cyc(2);
    check("rst_clr_n", {31'd0, a_clr_n}, 32'd0);
    check("rst_sclk",  {31'd0, a_sclk},  32'd0);
    check("rst_sout",  {31'd0, a_sout},  32'd0);
    check("rst_rck",   {31'd0, a_rck},   32'd0);
    check("rst_busy",  {31'd0, a_busy},  32'd0);
    check("rst_done",  {31'd0, a_done},  32'd0);
    check("rst_g_n",   {31'd0, a_g_n},   32'd1);
    rst = 4'h0;
    cyc(1);
    check("clr_n_release", {31'd0, a_clr_n}, 32'd1);

    clr_mon(0);
    cyc(20);
    check("idle_rises", mon[0].rises, 0);
    check("idle_busy",  mon[0].busy_cyc, 0);

    oea = 1'b1;
    check("g_n_latency", {31'd0, a_g_n}, 32'd1);
    cyc(1);
    check("g_n_follow", {31'd0, a_g_n}, 32'd0);

    // Table-driven single frames.
    for (int v = 0; v < 8; v++) begin
      k = vt[v].sel;
      clr_mon(k);
      if (k == 0) da = vt[v].data[7:0];
      else        db = vt[v].data;
      pulse(k);
      check("busy_after_launch", {31'd0, (k == 0) ? a_busy : b_busy}, 32'd1);
      wait_dones(k, 1, 200, "frame");
      cyc(3);
      check("bits",     {16'd0, mon[k].bits}, {16'd0, vt[v].exp_bits});
      check("rises",    mon[k].rises,    vt[v].exp_rises);
      check("busy_len", mon[k].busy_cyc, vt[v].exp_busy);
      check("rck_len",  mon[k].rck_cyc,  vt[v].exp_rck);
      check("dones",    mon[k].dones,    1);
      check("overlap",  mon[k].overlap,  0);
      check("sout_end", {31'd0, (k == 0) ? a_sout : b_sout}, 32'd0);
    end

    // Two starts while busy: one pending frame, data sampled at its launch.
    clr_mon(0);
    da = 8'hC3;
    pulse(0);
    cyc(5);
    da = 8'h5A;
    pulse(0);
    cyc(3);
    pulse(0);
    wait_dones(0, 2, 300, "pending");
    cyc(40);
    check("pend_dones", mon[0].dones, 2);
    check("pend_bits",  {16'd0, mon[0].bits}, 32'h0000C35A);
    check("pend_rises", mon[0].rises, 16);
    check("pend_busy",  mon[0].busy_cyc, 68);

    // Start in the done cycle launches immediately.
    clr_mon(0);
    da = 8'h0F;
    pulse(0);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!a_done && i < 100);
    check("done_seen", {31'd0, a_done}, 32'd1);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    check("start_on_done", {31'd0, a_busy}, 32'd1);
    wait_dones(0, 2, 200, "start_on_done");
    cyc(3);
    check("sod_dones", mon[0].dones, 2);
    check("sod_bits",  {16'd0, mon[0].bits}, 32'h00000F0F);

    // Reset in the middle of a frame.
    clr_mon(0);
    da = 8'hFF;
    pulse(0);
    i = 0;
    while (mon[0].rises < 4 && i < 100) begin
      cyc(1);
      i++;
    end
    check("abort_reach_bit4", mon[0].rises, 4);
    rst[0] = 1'b1;
    cyc(1);
    check("abort_sclk",  {31'd0, a_sclk},  32'd0);
    check("abort_rck",   {31'd0, a_rck},   32'd0);
    check("abort_busy",  {31'd0, a_busy},  32'd0);
    check("abort_clr_n", {31'd0, a_clr_n}, 32'd0);
    check("abort_g_n",   {31'd0, a_g_n},   32'd1);
    rst[0] = 1'b0;
    cyc(80);
    check("abort_no_rck",   mon[0].rck_cyc, 0);
    check("abort_no_done",  mon[0].dones, 0);

    // Data-change triggering.
    clr_mon(2);
    cyc(30);
    check("chg_quiet", mon[2].busy_cyc, 0);
    dc = 8'h3C;
    wait_dones(2, 1, 200, "chg_frame");
    cyc(200);
    check("chg_dones", mon[2].dones, 1);
    check("chg_bits",  {16'd0, mon[2].bits}, 32'h0000003C);
    check("chg_rises", mon[2].rises, 8);

    clr_mon(2);
    dc = 8'h55;
    cyc(10);
    dc = 8'h66;
    cyc(10);
    dc = 8'h55;
    wait_dones(2, 1, 200, "chg_revert");
    cyc(60);
    check("chg_revert_dones", mon[2].dones, 1);
    check("chg_revert_bits",  {16'd0, mon[2].bits}, 32'h00000055);

    clr_mon(2);
    dc = 8'h0F;
    cyc(10);
    dc = 8'hF0;
    wait_dones(2, 2, 300, "chg_follow");
    cyc(60);
    check("chg_follow_dones", mon[2].dones, 2);
    check("chg_follow_bits",  {16'd0, mon[2].bits}, 32'h00000FF0);

    // Continuous refresh: done-to-done period is one frame plus the done cycle.
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!d_done && i < 100);
    check("cont_done_seen", {31'd0, d_done}, 32'd1);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!d_done && i < 100);
    check("cont_period", i, frame_cycles(8, 1) + 1);
    check("cont_bits", {16'd0, mon[3].bits & 16'h00FF}, 32'h00000081);
    check("cont_overlap", mon[3].overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
